// File: rtl/sync_filter.sv
// sync_filter
//   Multi-channel synchronizer followed by a per-channel glitch filter.
//   Each input bit passes through a STAGES-deep flop chain. The filtered
//   output q only takes a new value once the synchronized value has
//   differed from q for FILTER_CYCLES consecutive rising edges. rise and
//   fall pulse for one cycle in the cycle q first shows its new value.
//   Channels share no logic.
//
// Parameters
//   WIDTH         number of independent channels (>= 1)
//   STAGES        synchronizer depth per channel (>= 2)
//   FILTER_CYCLES cycles a change must persist before acceptance (>= 1)
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   d      in   [WIDTH] asynchronous level inputs
//   raw_q  out  [WIDTH] synchronized, unfiltered (last chain flop)
//   q      out  [WIDTH] synchronized, glitch-filtered
//   rise   out  [WIDTH] one-cycle pulse on accepted 0->1 of q
//   fall   out  [WIDTH] one-cycle pulse on accepted 1->0 of q
module sync_filter #(
    parameter int WIDTH         = 4,
    parameter int STAGES        = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] raw_q,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [STAGES-1:0] chain;
        logic [CW-1:0]     cnt;
        logic              raw;
        logic              q_r;
        logic              rise_r;
        logic              fall_r;

        assign raw = chain[STAGES-1];

        // Synchronizer: bit 0 samples the asynchronous input, the top bit
        // is the first one considered safe to use.
        // NOTE: every flop here is cleared by the asynchronous reset so the
        // filter never starts from an unknown level and emits a bogus pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain <= '0;
            end else begin
                // NOTE: non-blocking assignments keep every flop sampling the
                // pre-edge value, which is what makes this a shift chain.
                chain <= {chain[STAGES-2:0], d[i]};
            end
        end

        // Filter: cnt counts consecutive edges on which raw disagrees with q.
        // Any edge where they agree clears it, so separate short excursions
        // never accumulate. On the FILTER_CYCLES-th disagreeing edge q takes
        // the new value and cnt returns to 0, so cnt never exceeds CNT_MAX.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                q_r    <= 1'b0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                if (raw == q_r) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt    <= '0;
                    q_r    <= raw;
                    rise_r <= raw;
                    fall_r <= ~raw;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign raw_q[i] = raw;
        assign q[i]     = q_r;
        assign rise[i]  = rise_r;
        assign fall[i]  = fall_r;
    end

endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels, minimum 1.
REQ-002 Parameter STAGES, default 2: synchronizer flop-chain depth per channel, minimum 2.
REQ-003 Parameter FILTER_CYCLES, default 4: consecutive cycles a changed synchronized value must hold before acceptance, minimum 1.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port d  input  WIDTH  asynchronous level inputs, one bit per channel.
REQ-007 Port raw_q  output  WIDTH  synchronized, unfiltered value (last flop of each chain).
REQ-008 Port q  output  WIDTH  synchronized, glitch-filtered value.
REQ-009 Port rise  output  WIDTH  one-cycle pulse per channel on accepted 0->1 of q.
REQ-010 Port fall  output  WIDTH  one-cycle pulse per channel on accepted 1->0 of q.

Function
REQ-011 Each channel SHALL be fully independent; no cross-channel logic or shared counters.
REQ-012 Each channel SHALL pass d through STAGES flops; raw_q SHALL reflect d sampled STAGES rising edges earlier.
REQ-013 Each channel SHALL hold a counter cnt of width max(1, $clog2(FILTER_CYCLES)).
REQ-014 At each rising edge, if raw_q == q: cnt <= 0; q, rise, fall unchanged except rise/fall <= 0.
REQ-015 At each rising edge, if raw_q != q and cnt < FILTER_CYCLES-1: cnt <= cnt+1; q unchanged; rise/fall <= 0.
REQ-016 At each rising edge, if raw_q != q and cnt == FILTER_CYCLES-1: q <= raw_q; cnt <= 0; rise <= raw_q; fall <= ~raw_q.
REQ-017 rise/fall SHALL be high exactly in the first cycle q shows the new value, never longer than one cycle, never both high on one channel.
REQ-018 Latency from a stable d change to q SHALL be exactly STAGES+FILTER_CYCLES rising edges; FILTER_CYCLES=1 gives STAGES+1.
REQ-019 A raw_q excursion shorter than FILTER_CYCLES cycles SHALL be fully rejected: q unchanged, no rise/fall, cnt returns to 0.
REQ-020 A raw_q toggle back mid-count SHALL clear cnt; the next change restarts counting from 0 (no accumulation across excursions).
REQ-021 cnt SHALL never exceed FILTER_CYCLES-1 (no wrap-around).
REQ-022 Outputs q, rise, fall, raw_q SHALL be driven directly from flops (no combinational path from d).

Reset
REQ-023 While rst_n is low, all synchronizer flops, q, cnt, rise and fall SHALL be 0, asynchronously to clk.
REQ-024 Reset asserted mid-count or mid-pulse SHALL abort immediately: q=0, cnt=0, rise=fall=0, no pulse emitted later.
REQ-025 After rst_n release, a channel with d held high SHALL need the full STAGES+FILTER_CYCLES edges before q=1 with a single rise pulse.

Verification (WIDTH=4, STAGES=2, FILTER_CYCLES=4, 10 ns clk unless stated)
REQ-026 rst_n=0, d=4'hF for 5 cycles -> raw_q=q=rise=fall=4'h0 throughout.
REQ-027 After reset, d[0] 0->1 held -> raw_q[0]=1 after edge 2, q[0]=1 after edge 6, rise[0]=1 for exactly that one cycle.
REQ-028 d[1] high for 3 cycles then low -> raw_q[1] pulses 3 cycles; q[1]=0, rise[1]=fall[1]=0 throughout.
REQ-029 d=4'b1010 then (after q settles) d=4'b0101 -> q=4'b1010 with rise=4'b1010 in one cycle; later q=4'b0101 with rise=4'b0101 and fall=4'b1010 in the same single cycle.
REQ-030 d=4'hF, rst_n pulsed low when cnt=2 -> q=0 immediately, no rise; after release q=4'hF exactly 6 edges later with one rise=4'hF pulse.
REQ-031 STAGES=3, FILTER_CYCLES=1: d[2] 0->1 -> q[2]=1 after edge 4; 1-cycle d glitch aligned to a sample edge propagates (no filtering).
